// File: rtl/bsg_array_concentrate_pkg.sv
// bsg_array_concentrate_pkg: state encoding and row-slice helper shared by the concentrate serializer.
`ifndef BSG_ROW_SLICE
`define BSG_ROW_SLICE(k, w) [(k)*(w) +: (w)]
`endif

package bsg_array_concentrate_pkg;

    typedef enum logic [0:0] {e_idle, e_send} state_e;

endpackage

// File: rtl/bsg_priority_encode_lo.sv
// bsg_priority_encode_lo: index and found flag of the lowest set bit of a vector.
module bsg_priority_encode_lo #(
    parameter int els_p     = 2,
    parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic [els_p-1:0]     v,
    output logic [lg_els_lp-1:0] idx,
    output logic                 found
);

    assign found = |v;

    // Scan high to low so the lowest set bit is the final write.
    always_comb begin
        idx = '0;
        for (int i = els_p - 1; i >= 0; i--)
            if (v[i]) idx = lg_els_lp'(i);
    end

endmodule

// File: rtl/bsg_array_concentrate_serializer.sv
// bsg_array_concentrate_serializer: captures one concentrated array and emits its kept rows
// one per transfer in ascending row order.
module bsg_array_concentrate_serializer
    import bsg_array_concentrate_pkg::*;
#(
    parameter int width_p   = 128,
    parameter int els_p     = 2,
    parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    input  logic [els_p*width_p-1:0] data_i,
    input  logic [els_p-1:0]         mask_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [width_p-1:0]       data_o,
    output logic [lg_els_lp-1:0]     row_id_o,
    output logic                     last_o,
    input  logic                     yumi_i
);

    state_e                   state_r;
    logic [els_p*width_p-1:0] data_r;
    logic [els_p-1:0]         mask_r, rem;
    logic [lg_els_lp-1:0]     ptr_r, first_idx, next_idx;
    logic                     first_found, next_found;

    assign valid_o  = state_r == e_send;
    assign data_o   = data_r `BSG_ROW_SLICE(ptr_r, width_p);
    assign row_id_o = ptr_r;
    assign last_o   = valid_o & $onehot(mask_r);
    assign ready_o  = !valid_o | (last_o & yumi_i);
    // Rows below the pointer are already cleared, so dropping the current bit leaves only later rows.
    assign rem      = mask_r & ~(els_p'(1) << ptr_r);

    bsg_priority_encode_lo #(.els_p(els_p), .lg_els_lp(lg_els_lp)) first_enc (
        .v(mask_i), .idx(first_idx), .found(first_found)
    );

    bsg_priority_encode_lo #(.els_p(els_p), .lg_els_lp(lg_els_lp)) next_enc (
        .v(rem), .idx(next_idx), .found(next_found)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            data_r  <= '0;
            mask_r  <= '0;
            ptr_r   <= '0;
        end else begin
            if (valid_o && yumi_i) begin
                mask_r <= rem;
                ptr_r  <= next_idx;
                if (!next_found) state_r <= e_idle;
            end
            // A new array may land in the same cycle the last row leaves; it overrides the drain update.
            if (valid_i && ready_o && first_found) begin
                state_r <= e_send;
                data_r  <= data_i;
                mask_r  <= mask_i;
                ptr_r   <= first_idx;
            end
        end
    end

endmodule

// File: tb/tb_bsg_array_concentrate_serializer.sv
// tb_bsg_array_concentrate_serializer: directed vectors plus a queue-scoreboarded random phase.
module tb_bsg_array_concentrate_serializer;

    localparam int W = 16;
    localparam int E = 2;

    logic          clk_i = 0;
    logic          reset_i = 1;
    logic          valid_i = 0;
    logic [E*W-1:0] data_i = '0;
    logic [E-1:0]  mask_i = '0;
    logic          ready_o, valid_o, last_o, yumi_i = 0;
    logic [W-1:0]  data_o;
    logic [0:0]    row_id_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [0:0]   id;
        logic         last;
    } row_t;
    row_t q[$];

    bsg_array_concentrate_serializer #(.width_p(W), .els_p(E)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i),
        .mask_i(mask_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
        .row_id_o(row_id_o), .last_o(last_o), .yumi_i(yumi_i)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i)
        if (!reset_i && yumi_i && !valid_o) $error("yumi_i asserted while valid_o low");

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic out(input string tag, input logic v, input logic [W-1:0] d,
                       input logic id, input logic l, input logic r);
        #1;
        check({tag, ".valid"}, valid_o, v);
        if (v) begin
            check({tag, ".data"}, data_o, d);
            check({tag, ".id"}, row_id_o, id);
        end
        check({tag, ".last"}, last_o, l);
        check({tag, ".ready"}, ready_o, r);
    endtask

    initial begin
        #2;
        out("reset", 0, 0, 0, 0, 1);
        check("reset.data", data_o, 0);
        check("reset.id", row_id_o, 0);
        tick();
        reset_i = 0;
        tick();

        // full mask, yumi held
        valid_i = 1; data_i = {16'hBBBB, 16'hAAAA}; mask_i = 2'b11;
        tick();
        valid_i = 0; yumi_i = 1;
        out("m11.r0", 1, 16'hAAAA, 0, 0, 0);
        tick();
        out("m11.r1", 1, 16'hBBBB, 1, 1, 1);
        tick();
        yumi_i = 0;
        out("m11.done", 0, 0, 0, 0, 1);

        // only row 1 kept
        valid_i = 1; data_i = {16'h1111, 16'h0000}; mask_i = 2'b10;
        tick();
        valid_i = 0;
        out("m10.stall", 1, 16'h1111, 1, 1, 0);
        yumi_i = 1;
        out("m10.take", 1, 16'h1111, 1, 1, 1);
        tick();
        yumi_i = 0;
        out("m10.done", 0, 0, 0, 0, 1);

        // empty mask is dropped
        valid_i = 1; data_i = {16'h2222, 16'h3333}; mask_i = 2'b00;
        out("m00.offer", 0, 0, 0, 0, 1);
        tick();
        valid_i = 0;
        out("m00.after", 0, 0, 0, 0, 1);
        tick();
        out("m00.after2", 0, 0, 0, 0, 1);

        // back-to-back arrays with no bubble
        valid_i = 1; data_i = {16'hC001, 16'hC000}; mask_i = 2'b11;
        tick();
        data_i = {16'hD001, 16'hD000}; mask_i = 2'b01; yumi_i = 1;
        out("b2b.x0", 1, 16'hC000, 0, 0, 0);
        tick();
        out("b2b.x1", 1, 16'hC001, 1, 1, 1);
        tick();
        valid_i = 0;
        out("b2b.y0", 1, 16'hD000, 0, 1, 1);
        tick();
        yumi_i = 0;
        out("b2b.done", 0, 0, 0, 0, 1);

        // consumer stall while the producer keeps offering other arrays
        valid_i = 1; data_i = {16'hE001, 16'hE000}; mask_i = 2'b11;
        tick();
        for (int i = 0; i < 5; i++) begin
            valid_i = i[0]; data_i = {16'hF0F0, 16'h0F0F} ^ E*W'(i); mask_i = 2'b11;
            out("stall", 1, 16'hE000, 0, 0, 0);
            tick();
        end
        valid_i = 0; yumi_i = 1;
        out("stall.r0", 1, 16'hE000, 0, 0, 0);
        tick();
        out("stall.r1", 1, 16'hE001, 1, 1, 1);
        tick();
        yumi_i = 0;
        out("stall.done", 0, 0, 0, 0, 1);

        // asynchronous reset mid-array
        valid_i = 1; data_i = {16'h5151, 16'h5050}; mask_i = 2'b11;
        tick();
        valid_i = 0;
        out("rst.pre", 1, 16'h5050, 0, 0, 0);
        reset_i = 1;
        out("rst.mid", 0, 0, 0, 0, 1);
        check("rst.data", data_o, 0);
        tick();
        reset_i = 0;
        valid_i = 1; data_i = {16'h7171, 16'h7070}; mask_i = 2'b01;
        tick();
        valid_i = 0; yumi_i = 1;
        out("rst.new", 1, 16'h7070, 0, 1, 1);
        tick();
        yumi_i = 0;
        out("rst.done", 0, 0, 0, 0, 1);

        // random traffic against a queue scoreboard
        for (int c = 0; c < 3000; c++) begin
            check("rnd.valid", valid_o, q.size() != 0);
            if (valid_o && q.size() != 0) begin
                check("rnd.data", data_o, q[0].d);
                check("rnd.id", row_id_o, q[0].id);
                check("rnd.last", last_o, q[0].last);
            end
            yumi_i = valid_o & ($urandom_range(0, 3) != 0);
            valid_i = $urandom_range(0, 1);
            mask_i = E'($urandom_range(0, 3));
            data_i = {16'($urandom), 16'($urandom)};
            #1;
            check("rnd.ready", ready_o, q.size() == 0 || (q.size() == 1 && yumi_i));
            if (yumi_i && q.size() != 0) void'(q.pop_front());
            if (valid_i && ready_o)
                for (int k = 0; k < E; k++)
                    if (mask_i[k])
                        q.push_back('{d: data_i[k*W +: W], id: k[0], last: (mask_i >> (k + 1)) == 0});
            tick();
        end
        valid_i = 0;
        for (int c = 0; c < 10 && valid_o; c++) begin
            yumi_i = 1;
            if (q.size() != 0) begin
                check("drain.data", data_o, q[0].d);
                void'(q.pop_front());
            end
            tick();
        end
        yumi_i = 0;
        #1;
        check("drain.empty", q.size(), 0);
        check("drain.valid", valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
